// File: rtl/pwm_pkg.sv
// Shared PWM-leg definitions: FSM states, last-conducting-gate tracking and fault codes.
// Used by the dead-time, monitor and SVM blocks.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_HI_ON = 2'd1,
    ST_LO_ON = 2'd2,
    ST_FAULT = 2'd3
  } dt_state_e;

  typedef enum logic [1:0] {
    LAST_NONE = 2'd0,
    LAST_HI   = 2'd1,
    LAST_LO   = 2'd2
  } last_gate_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_OVERLAP  = 2'b01;
  localparam logic [1:0] FC_DT_SHORT = 2'b10;

endpackage

// File: rtl/dead_time_monitor_if.sv
// Gate-pair monitor bundle: gate commands and clear request in, protection status out.
interface dead_time_monitor_if #(
  parameter int CNT_W  = 11,
  parameter int FCNT_W = 8
);
  logic              gate_hi;
  logic              gate_lo;
  logic              fault_clr;
  logic              gate_en;
  logic              fault;
  logic [1:0]        fault_code;
  logic [CNT_W-1:0]  dt_meas;
  logic              dt_valid;
  logic [FCNT_W-1:0] fault_cnt;

  modport master (
    output gate_hi, gate_lo, fault_clr,
    input  gate_en, fault, fault_code, dt_meas, dt_valid, fault_cnt
  );

  modport slave (
    input  gate_hi, gate_lo, fault_clr,
    output gate_en, fault, fault_code, dt_meas, dt_valid, fault_cnt
  );
endinterface

// File: rtl/dead_time_monitor.sv
// Per-leg dead-time monitor: measures hi/lo hand-over gaps, latches overlap or short-gap faults
// and withholds gate_en until a clear request arrives with both gates off.
module dead_time_monitor
  import pwm_pkg::*;
#(
  parameter int CNT_W  = 11,
  parameter int DT_MIN = 195,
  parameter int FCNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  dead_time_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = '1;
  localparam logic [CNT_W-1:0]  DT_MIN_C = CNT_W'(DT_MIN);

  dt_state_e         state;
  last_gate_e        last;
  logic [CNT_W-1:0]  cnt;
  logic              gate_en_q;
  logic              fault_q;
  logic [1:0]        fault_code_q;
  logic [CNT_W-1:0]  dt_meas_q;
  logic              dt_valid_q;
  logic [FCNT_W-1:0] fault_cnt_q;

  logic       hi, lo;
  logic       fault_hit;
  logic [1:0] fault_cause;
  logic       meas_ok;
  last_gate_e cur_gate;

  assign hi       = mon.gate_hi;
  assign lo       = mon.gate_lo;
  assign cur_gate = hi ? LAST_HI : LAST_LO;

  // Fault and hand-over decode for the current sample.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    fault_hit   = 1'b0;
    fault_cause = FC_NONE;
    meas_ok     = 1'b0;
    case (state)
      ST_GAP: begin
        if (hi && lo) begin
          fault_hit   = 1'b1;
          fault_cause = FC_OVERLAP;
        end else if ((hi ^ lo) && (last != LAST_NONE) && (cur_gate != last)) begin
          if (cnt < DT_MIN_C) begin
            fault_hit   = 1'b1;
            fault_cause = FC_DT_SHORT;
          end else begin
            meas_ok = 1'b1;
          end
        end
      end
      ST_HI_ON: if (lo) begin
        fault_hit   = 1'b1;
        fault_cause = hi ? FC_OVERLAP : FC_DT_SHORT;
      end
      ST_LO_ON: if (hi) begin
        fault_hit   = 1'b1;
        fault_cause = lo ? FC_OVERLAP : FC_DT_SHORT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GAP;
      last         <= LAST_NONE;
      cnt          <= '0;
      gate_en_q    <= 1'b1;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      dt_meas_q    <= '0;
      dt_valid_q   <= 1'b0;
      fault_cnt_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      dt_valid_q <= 1'b0;
      if (fault_hit) begin
        state        <= ST_FAULT;
        fault_q      <= 1'b1;
        gate_en_q    <= 1'b0;
        fault_code_q <= fault_cause;
        if (fault_cnt_q != FCNT_MAX) fault_cnt_q <= fault_cnt_q + 1'b1;
      end else begin
        case (state)
          ST_GAP: begin
            if (!hi && !lo) begin
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else begin
              state <= hi ? ST_HI_ON : ST_LO_ON;
              last  <= cur_gate;
              if (meas_ok) begin
                dt_meas_q  <= cnt;
                dt_valid_q <= 1'b1;
              end
            end
          end
          // The cycle a gate falls already counts as the first gap cycle.
          ST_HI_ON: if (!hi) begin
            state <= ST_GAP;
            cnt   <= CNT_W'(1);
          end
          ST_LO_ON: if (!lo) begin
            state <= ST_GAP;
            cnt   <= CNT_W'(1);
          end
          ST_FAULT: if (mon.fault_clr && !hi && !lo) begin
            state        <= ST_GAP;
            last         <= LAST_NONE;
            cnt          <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            gate_en_q    <= 1'b1;
          end
          default: state <= ST_GAP;
        endcase
      end
    end
  end

  assign mon.gate_en    = gate_en_q;
  assign mon.fault      = fault_q;
  assign mon.fault_code = fault_code_q;
  assign mon.dt_meas    = dt_meas_q;
  assign mon.dt_valid   = dt_valid_q;
  assign mon.fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_dead_time_monitor.sv
// Self-checking bench for dead_time_monitor: phase table with scoreboard queue plus hand-written
// reset and counter-saturation sequences.
module tb_dead_time_monitor;

  localparam int CNT_W  = 11;
  localparam int DT_MIN = 195;
  localparam int FCNT_W = 8;

  typedef struct {
    string       name;
    logic        hi;
    logic        lo;
    logic        clr;
    int          cycles;
    logic        en;
    logic        flt;
    logic [1:0]  code;
    logic [10:0] dt;
    logic        valid;
    logic [7:0]  fcnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  vec_t tbl[$];
  vec_t sb_q[$];

  dead_time_monitor_if #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) bus ();

  dead_time_monitor #(.CNT_W(CNT_W), .DT_MIN(DT_MIN), .FCNT_W(FCNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pack_out();
    return {bus.gate_en, bus.fault, bus.fault_code, bus.dt_meas, bus.dt_valid, bus.fault_cnt};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got en=%0b flt=%0b code=%0d dt=%0d vld=%0b fcnt=%0d, want en=%0b flt=%0b code=%0d dt=%0d vld=%0b fcnt=%0d",
               name, act[23], act[22], act[21:20], act[19:9], act[8], act[7:0],
               exp[23], exp[22], exp[21:20], exp[19:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic add(input string name, input logic hi, input logic lo, input logic clr, input int cycles,
                     input logic en, input logic flt, input logic [1:0] code, input int dt,
                     input logic valid, input int fcnt);
    vec_t v;
    v.name = name; v.hi = hi; v.lo = lo; v.clr = clr; v.cycles = cycles;
    v.en = en; v.flt = flt; v.code = code; v.dt = 11'(dt); v.valid = valid; v.fcnt = 8'(fcnt);
    tbl.push_back(v);
  endtask

  // Drive one set of inputs for one clock; outputs are sampled on the following negedge.
  task automatic cycle(input logic hi, input logic lo, input logic clr);
    bus.gate_hi   = hi;
    bus.gate_lo   = lo;
    bus.fault_clr = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t exp_v;
    checks   = 0;
    failures = 0;
    bus.gate_hi   = 1'b0;
    bus.gate_lo   = 1'b0;
    bus.fault_clr = 1'b0;
    rst_n         = 1'b0;

    //   name           hi lo clr cyc   en f code dt   vld fcnt
    add("idle",          0, 0, 0,   10, 1, 0, 0,   0,   0, 0);
    add("first_edge",    0, 1, 0,    1, 1, 0, 0,   0,   0, 0);
    add("lo_hold",       0, 1, 0,   20, 1, 0, 0,   0,   0, 0);
    add("lo_gap3",       0, 0, 0,    3, 1, 0, 0,   0,   0, 0);
    add("lo_same_gate",  0, 1, 0,    1, 1, 0, 0,   0,   0, 0);
    add("lo_long",       0, 1, 0,  500, 1, 0, 0,   0,   0, 0);
    add("gap200",        0, 0, 0,  200, 1, 0, 0,   0,   0, 0);
    add("hi_hand200",    1, 0, 0,    1, 1, 0, 0, 200,   1, 0);
    add("hi_hold",       1, 0, 0,  499, 1, 0, 0, 200,   0, 0);
    add("hi_gap3a",      0, 0, 0,    3, 1, 0, 0, 200,   0, 0);
    add("hi_same_a",     1, 0, 0,    1, 1, 0, 0, 200,   0, 0);
    add("hi_gap3b",      0, 0, 0,    3, 1, 0, 0, 200,   0, 0);
    add("hi_same_b",     1, 0, 0,    1, 1, 0, 0, 200,   0, 0);
    add("gap195",        0, 0, 0,  195, 1, 0, 0, 200,   0, 0);
    add("lo_min_legal",  0, 1, 0,    1, 1, 0, 0, 195,   1, 0);
    add("lo_hold2",      0, 1, 0,   10, 1, 0, 0, 195,   0, 0);
    add("gap194",        0, 0, 0,  194, 1, 0, 0, 195,   0, 0);
    add("hi_short194",   1, 0, 0,    1, 0, 1, 2, 195,   0, 1);
    add("flt_overlap",   1, 1, 0,    3, 0, 1, 2, 195,   0, 1);
    add("clr_with_hi",   1, 0, 1,    5, 0, 1, 2, 195,   0, 1);
    add("clr_ok",        0, 0, 1,    1, 1, 0, 0, 195,   0, 1);
    add("idle2",         0, 0, 0,   10, 1, 0, 0, 195,   0, 1);
    add("hi_after_clr",  1, 0, 0,    1, 1, 0, 0, 195,   0, 1);
    add("hi_overlap",    1, 1, 0,    1, 0, 1, 1, 195,   0, 2);
    add("overlap_more",  1, 1, 0,    4, 0, 1, 1, 195,   0, 2);
    add("clr2",          0, 0, 1,    1, 1, 0, 0, 195,   0, 2);
    add("hi_first2",     1, 0, 0,    4, 1, 0, 0, 195,   0, 2);
    add("zero_gap",      0, 1, 0,    1, 0, 1, 2, 195,   0, 3);
    add("clr3",          0, 0, 1,    1, 1, 0, 0, 195,   0, 3);
    add("lo_first3",     0, 1, 0,    6, 1, 0, 0, 195,   0, 3);
    add("gap150",        0, 0, 0,  150, 1, 0, 0, 195,   0, 3);
    add("hi_short150",   1, 0, 0,    1, 0, 1, 2, 195,   0, 4);
    add("clr4",          0, 0, 1,    1, 1, 0, 0, 195,   0, 4);
    add("gap_overlap",   1, 1, 0,    1, 0, 1, 1, 195,   0, 5);
    add("clr5",          0, 0, 1,    1, 1, 0, 0, 195,   0, 5);
    add("clr_no_fault",  0, 0, 1,    5, 1, 0, 0, 195,   0, 5);
    add("hi_with_clr",   1, 0, 1,    3, 1, 0, 0, 195,   0, 5);
    add("ovl_beats_clr", 1, 1, 1,    1, 0, 1, 1, 195,   0, 6);
    add("clr6",          0, 0, 1,    1, 1, 0, 0, 195,   0, 6);
    add("hi_pre_sat",    1, 0, 0,    2, 1, 0, 0, 195,   0, 6);
    add("gap3000",       0, 0, 0, 3000, 1, 0, 0, 195,   0, 6);
    add("lo_sat",        0, 1, 0,    1, 1, 0, 0, 2047,  1, 6);
    add("lo_hold3",      0, 1, 0,    2, 1, 0, 0, 2047,  0, 6);
    add("lo_gap_tail",   0, 0, 0,   50, 1, 0, 0, 2047,  0, 6);

    repeat (3) @(negedge clk);
    check("reset_state", pack_out(), {1'b1, 1'b0, 2'd0, 11'd0, 1'b0, 8'd0});
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      sb_q.push_back(tbl[i]);
      for (int c = 0; c < tbl[i].cycles; c++) cycle(tbl[i].hi, tbl[i].lo, tbl[i].clr);
      exp_v = sb_q.pop_front();
      check(exp_v.name, pack_out(), {exp_v.en, exp_v.flt, exp_v.code, exp_v.dt, exp_v.valid, exp_v.fcnt});
    end

    // Reset asserted in the middle of a gap: outputs must return at once, without a clock edge.
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_gap", pack_out(), {1'b1, 1'b0, 2'd0, 11'd0, 1'b0, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset is never checked, even with a gap far below DT_MIN.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("post_reset_edge", pack_out(), {1'b1, 1'b0, 2'd0, 11'd0, 1'b0, 8'd0});

    // Hand-over from that first edge is checked: 2-cycle gap is short.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("post_reset_short", pack_out(), {1'b0, 1'b1, 2'd2, 11'd0, 1'b0, 8'd1});
    cycle(1'b0, 1'b0, 1'b1);

    // Fault counter saturates at all-ones and never wraps.
    for (int k = 0; k < 259; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
    end
    check("fcnt_saturate", pack_out(), {1'b1, 1'b0, 2'd0, 11'd0, 1'b0, 8'd255});

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
